// File: rtl/toy_commit_credit_sink.sv
// Commit-queue intake: circular buffer filled from the fetch read lanes, drained by retire lanes,
// retired slots returned as credits one cycle later. Define TOY_COMMIT_IDX_CHECK_EN for idx sequencing checks.
module toy_commit_credit_sink #(
   parameter int unsigned DEPTH          = 32,
   parameter int unsigned LANES          = 8,
   parameter int unsigned RETIRE_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned INST_WIDTH_32  = 32,
   parameter int unsigned INST_IDX_WIDTH = 8
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          cancel_en,
   input  logic [LANES-1:0]                              v_ack_vld,
   output logic [LANES-1:0]                              v_ack_rdy,
   input  logic [LANES-1:0][ADDR_WIDTH-1:0]              v_ack_pc,
   input  logic [LANES-1:0][INST_WIDTH_32-1:0]           v_ack_pld,
   input  logic [LANES-1:0][INST_IDX_WIDTH-1:0]          v_ack_idx,
   output logic [RETIRE_WIDTH-1:0]                       retire_vld,
   input  logic [RETIRE_WIDTH-1:0]                       retire_rdy,
   output logic [RETIRE_WIDTH-1:0][ADDR_WIDTH-1:0]       retire_pc,
   output logic [RETIRE_WIDTH-1:0][INST_WIDTH_32-1:0]    retire_pld,
   output logic [RETIRE_WIDTH-1:0][INST_IDX_WIDTH-1:0]   retire_idx,
   output logic                                          commit_credit_rel_en,
   output logic [2:0]                                    commit_credit_rel_num,
   output logic                                          proto_err
);

   localparam int unsigned SW = $clog2(DEPTH);
   localparam int unsigned PW = SW + 1;
   localparam int unsigned KW = $clog2(LANES + 1);
   localparam int unsigned CW = ((PW > KW) ? PW : KW) + 1;
   localparam int unsigned IW = INST_IDX_WIDTH;

   logic [PW-1:0]            wr_ptr, rd_ptr, cnt, free_cnt;
   logic [ADDR_WIDTH-1:0]    mem_pc  [DEPTH];
   logic [INST_WIDTH_32-1:0] mem_pld [DEPTH];
   logic [IW-1:0]            mem_idx [DEPTH];
   logic [LANES-1:0]         wr_en;
   logic [CW-1:0]            acc_cnt;
   logic                     acc_stop, acc_gap, acc_ovf, idx_err;
   logic [2:0]               ret_cnt;
   logic                     ret_stop;
   logic [SW-1:0]            rd_slot;
   logic                     rel_en_q;
   logic [2:0]               rel_num_q;
   logic                     err_q;

   assign cnt       = wr_ptr - rd_ptr;
   assign free_cnt  = PW'(DEPTH) - cnt;
   assign v_ack_rdy = {LANES{~cancel_en}};

   // Accept the valid prefix, clipped to free space; gaps and excess lanes are flagged, never written.
   always_comb begin
      wr_en    = '0;
      acc_cnt  = '0;
      acc_stop = 1'b0;
      acc_gap  = 1'b0;
      acc_ovf  = 1'b0;
      for (int unsigned j = 0; j < LANES; j++) begin
         if (!v_ack_vld[j]) begin
            acc_stop = 1'b1;
         end else if (acc_stop) begin
            acc_gap = 1'b1;
         end else if (acc_cnt < CW'(free_cnt)) begin
            wr_en[j] = 1'b1;
            acc_cnt  = acc_cnt + 1'b1;
         end else begin
            acc_ovf = 1'b1;
         end
      end
      if (cancel_en) begin
         wr_en   = '0;
         acc_cnt = '0;
         acc_gap = 1'b0;
         acc_ovf = 1'b0;
      end
   end

`ifdef TOY_COMMIT_IDX_CHECK_EN
   logic [IW-1:0] exp_idx;

   always_comb begin
      idx_err = 1'b0;
      for (int unsigned j = 0; j < LANES; j++) begin
         if (wr_en[j] && (v_ack_idx[j] != exp_idx + IW'(j + 1))) idx_err = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         exp_idx <= '1;
      else if (cancel_en) exp_idx <= '1;
      else                exp_idx <= exp_idx + IW'(acc_cnt);
   end
`else
   assign idx_err = 1'b0;
`endif

   // Head view is purely from registers; retire count is the prefix of vld&rdy.
   always_comb begin
      retire_vld = '0;
      retire_pc  = '0;
      retire_pld = '0;
      retire_idx = '0;
      ret_cnt    = '0;
      ret_stop   = 1'b0;
      rd_slot    = '0;
      for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
         rd_slot       = rd_ptr[SW-1:0] + SW'(i);
         retire_vld[i] = ~cancel_en & (PW'(i) < cnt);
         retire_pc[i]  = mem_pc[rd_slot];
         retire_pld[i] = mem_pld[rd_slot];
         retire_idx[i] = mem_idx[rd_slot];
         if (!(retire_vld[i] && retire_rdy[i])) ret_stop = 1'b1;
         else if (!ret_stop)                    ret_cnt  = ret_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < LANES; j++) begin
         if (wr_en[j]) begin
            mem_pc [wr_ptr[SW-1:0] + SW'(j)] <= v_ack_pc[j];
            mem_pld[wr_ptr[SW-1:0] + SW'(j)] <= v_ack_pld[j];
            mem_idx[wr_ptr[SW-1:0] + SW'(j)] <= v_ack_idx[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rel_en_q  <= 1'b0;
         rel_num_q <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= err_q | acc_gap | acc_ovf | idx_err;
         if (cancel_en) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rel_en_q  <= 1'b0;
            rel_num_q <= '0;
         end else begin
            wr_ptr    <= wr_ptr + PW'(acc_cnt);
            rd_ptr    <= rd_ptr + PW'(ret_cnt);
            rel_en_q  <= (ret_cnt != 3'd0);
            rel_num_q <= ret_cnt;
         end
      end
   end

   // A release pending from the previous cycle is swallowed by a flush; producer resets its credit.
   assign commit_credit_rel_en  = rel_en_q & ~cancel_en;
   assign commit_credit_rel_num = cancel_en ? 3'd0 : rel_num_q;
   assign proto_err             = err_q;

endmodule
